// File: rtl/pipeline_pkg.sv
// Shared types for the memory arbiter: FSM states, bus owner, func3 mem_op codes.
package pipeline_pkg;

  typedef enum logic [1:0] {IDLE, IF_BUSY, LSU_BUSY} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;
  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;

  typedef struct packed {
    logic       we;
    logic [2:0] op;
  } bus_ctl_t;

endpackage

// File: rtl/mem_arbiter_pipeline_if.sv
// IF / LSU / memory-bus signal bundle; slave = arbiter view, master = core+memory view.
interface mem_arbiter_pipeline_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i, if_gnt_o, if_rvalid_o;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [2:0]        lsu_op_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i, lsu_rdata_o;
  logic              mem_req_o, mem_we_o, mem_ack_i;
  logic [2:0]        mem_op_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  logic              stall_if_o, err_o;

  modport slave (
    input  if_req_i, if_addr_i, lsu_req_i, lsu_we_i, lsu_op_i, lsu_addr_i, lsu_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
           mem_req_o, mem_we_o, mem_op_o, mem_addr_o, mem_wdata_o, stall_if_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, lsu_req_i, lsu_we_i, lsu_op_i, lsu_addr_i, lsu_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
           mem_req_o, mem_we_o, mem_op_o, mem_addr_o, mem_wdata_o, stall_if_o, err_o
  );
endinterface

// File: rtl/mem_arb_wait_ctr.sv
// Busy-cycle counter for the arbiter; flags the MAX_WAIT-th busy cycle as a timeout.
module mem_arb_wait_ctr #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // cnt counts completed busy cycles, so the MAX_WAIT-th busy cycle sees MAX_WAIT-1
  assign timeout = en && (cnt == LAST);
endmodule

// File: rtl/mem_arbiter_pipeline.sv
// IF/LSU arbiter for the single memory port. Define MEM_ARB_TIMEOUT_EN to enable
// the busy-wait timeout abort (err_o pulse, rvalid with zero data).
module mem_arbiter_pipeline
  import pipeline_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_WAIT      = 15,
  parameter int IF_STARVE_LIM = 2
) (
  input logic                   clk_i,
  input logic                   rst_i,
  mem_arbiter_pipeline_if.slave bus
);
  localparam int SW = (IF_STARVE_LIM > 0) ? $clog2(IF_STARVE_LIM + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE_LIM);

  arb_state_e        state;
  owner_e            owner;
  bus_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, lsu_rdata_q, rsp_data;
  logic              mem_req_q, if_rvalid_q, lsu_rvalid_q, err_q;
  logic [SW-1:0]     starve_cnt;
  logic              idle, if_force, lsu_win, if_win, timeout;

  assign idle     = (state == IDLE);
  assign owner    = (state == LSU_BUSY) ? OWN_LSU : OWN_IF;
  // IF overrides LSU priority once it has lost IF_STARVE_LIM arbitrations in a row
  assign if_force = bus.if_req_i && (starve_cnt == STARVE_MAX);
  assign lsu_win  = idle && !rst_i && bus.lsu_req_i && !if_force;
  assign if_win   = idle && !rst_i && bus.if_req_i && !lsu_win;
  assign rsp_data = bus.mem_ack_i ? bus.mem_rdata_i : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (if_win || lsu_win),
    .en      (!idle),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ctl_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt   <= '0;
    end else begin
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_win) begin
            state     <= LSU_BUSY;
            mem_req_q <= 1'b1;
            ctl_q     <= '{we: bus.lsu_we_i, op: bus.lsu_op_i};
            addr_q    <= bus.lsu_addr_i;
            wdata_q   <= bus.lsu_wdata_i;
            if (!bus.if_req_i)               starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
          end else if (if_win) begin
            state      <= IF_BUSY;
            mem_req_q  <= 1'b1;
            ctl_q      <= '{we: 1'b0, op: MEM_LW};
            addr_q     <= bus.if_addr_i;
            wdata_q    <= '0;
            starve_cnt <= '0;
          end
        end
        default: begin
          // ack beats a same-cycle timeout; a timeout completes with zero data
          if (bus.mem_ack_i || timeout) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            err_q     <= !bus.mem_ack_i;
            if (owner == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= rsp_data;
            end else begin
              lsu_rvalid_q <= 1'b1;
              if (!ctl_q.we) lsu_rdata_q <= rsp_data;
            end
          end
        end
      endcase
    end
  end

  assign bus.if_gnt_o     = if_win;
  assign bus.lsu_gnt_o    = lsu_win;
  assign bus.if_rvalid_o  = if_rvalid_q;
  assign bus.if_rdata_o   = if_rdata_q;
  assign bus.lsu_rvalid_o = lsu_rvalid_q;
  assign bus.lsu_rdata_o  = lsu_rdata_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = ctl_q.we;
  assign bus.mem_op_o     = ctl_q.op;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.err_o        = err_q;
  assign bus.stall_if_o   = !rst_i && ((bus.if_req_i && !if_win) || (state == IF_BUSY));
endmodule

// File: doc/mem_arbiter_pipeline.md
Name: mem_arbiter_pipeline

Overview:
- Shares the single memory port of the pipelined core between instruction fetch (IF) and the load/store unit (LSU, MEM stage).
- Arbitrates requests, holds the winning transaction on the memory bus until acknowledged, and returns the read data to the correct requester.
- Generates the IF stall while the LSU owns the port.
- Sits between the IF/MEM pipeline stages and the memory wrapper; `mem_op` uses the control-unit encoding (`func3`).

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, cycles without ack before timeout abort (timeout feature only)
- IF_STARVE_LIM, 2, consecutive LSU grants while IF is pending before IF is forced to win

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch data
- lsu_req_i  in  1  load/store request, held until lsu_gnt_o
- lsu_we_i  in  1  1 = store
- lsu_op_i  in  3  mem_op (func3: LB/LH/LW/LBU/LHU, SB/SH/SW)
- lsu_addr_i  in  ADDR_W  data address
- lsu_wdata_i  in  DATA_W  store data
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  load data valid or store complete (1-cycle pulse)
- lsu_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  bus request, held until mem_ack_i
- mem_we_o  out  1  bus write enable
- mem_op_o  out  3  bus access size/sign
- mem_addr_o  out  ADDR_W  bus address
- mem_wdata_o  out  DATA_W  bus write data
- mem_ack_i  in  1  bus transfer done; mem_rdata_i valid this cycle
- mem_rdata_i  in  DATA_W  bus read data
- stall_if_o  out  1  IF must hold PC
- err_o  out  1  timeout abort pulse (tied 0 without the timeout feature)

Behaviour:
- FSM states: IDLE, IF_BUSY, LSU_BUSY.
- Reset (async, immediate): state=IDLE; all outputs 0; starve counter 0; wait counter 0. mem_req_o drops the same instant rst_i rises, including mid-transaction. The aborted transaction never produces rvalid.
- Arbitration in IDLE:
  - Grant is combinational: gnt_o=1 for the winner in the same cycle as its req.
  - Request fields are latched into bus registers on that edge; the state moves to the matching *_BUSY.
  - Priority: LSU over IF, except when starve_cnt==IF_STARVE_LIM with IF pending; then IF wins.
- Starve counter:
  - Increments on each LSU grant while if_req_i=1.
  - Clears on any IF grant, or when if_req_i=0 at an LSU grant.
  - Saturates at IF_STARVE_LIM.
- *_BUSY:
  - mem_req_o=1 and mem_* outputs stay stable from the latched registers until mem_ack_i.
  - On the ack edge: rdata_o<=mem_rdata_i, the owner's rvalid_o pulses next cycle, state returns to IDLE.
  - Minimum request-to-rvalid latency is 3 cycles (grant, bus, rvalid). A new arbitration happens in the IDLE cycle where rvalid is high.
- For IF transactions, mem_we_o=0 and mem_op_o=3'b010 (LW).
- For stores, lsu_rdata_o is unchanged; lsu_rvalid_o still pulses.
- stall_if_o=1 when if_req_i=1 and if_gnt_o=0, or when state==IF_BUSY (fetch outstanding).
- Simultaneous requests: exactly one gnt per IDLE cycle. The loser keeps req asserted and is served next.
- A req deasserted before grant is legal and is dropped.
- No gnt is issued outside IDLE.
- mem_ack_i outside *_BUSY is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to *_BUSY and increments each busy cycle.
  - When it reaches MAX_WAIT without ack: mem_req_o drops, err_o pulses 1 cycle, the owner's rvalid_o pulses with rdata=0, state goes to IDLE.
  - An ack arriving in the same cycle as the timeout wins (normal completion, no err).
- Undefined: no counter; BUSY waits indefinitely; err_o tied to 0.

Decomposition:
- Package pipeline_pkg:
  - arb_state_e enum (IDLE, IF_BUSY, LSU_BUSY).
  - mem_op localparams (MEM_LB=3'b000, MEM_LH=3'b001, MEM_LW=3'b010, MEM_LBU=3'b100, MEM_LHU=3'b101).
  - Owner enum (OWN_IF, OWN_LSU).
- Sub-module mem_arb_wait_ctr: wait counter plus timeout compare, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- IF-only fetch: if_req_i=1, addr 0x100, ack after 2 busy cycles with rdata 0x00500093 -> if_gnt_o at cycle 0, mem_addr_o=0x100 and mem_op_o=010 stable, if_rvalid_o one cycle after ack with if_rdata_o=0x00500093, lsu_rvalid_o never 1.
- Simultaneous requests: if_req_i and lsu_req_i (load LW 0x2000) in the same cycle -> lsu_gnt_o first, stall_if_o=1 throughout, IF granted in the IDLE cycle after lsu_rvalid_o.
- Starvation: lsu_req_i held continuously with if_req_i pending -> LSU, LSU, then IF granted on the third arbitration.
- Store: lsu_we_i=1, SB, addr 0x2003, wdata 0xAB -> mem_we_o=1, mem_op_o=000, mem_wdata_o=0xAB, lsu_rvalid_o pulses, lsu_rdata_o unchanged.
- Reset mid-transaction: rst_i asserted during LSU_BUSY -> mem_req_o=0 immediately, state IDLE, no rvalid afterward.
- With MEM_ARB_TIMEOUT_EN: no ack for 15 cycles -> err_o pulse, owner rvalid with rdata=0. Ack on cycle 15 -> normal completion, err_o stays 0.
